int_sequencer: RTL and testbench
================================

# int_sequencer

Interrupt/reset sequencer for the 6502 core. Arbitrates RESET, NMI, IRQ and BRK, and runs the common 7-cycle vector sequence: forced-BRK injection, three stack pushes, vector fetch. It sits beside the instruction decoder and PLA. It tells the decoder when to substitute opcode 0x00, which cycle of the sequence is active, and which vector address to fetch. It also gates write strobes during the reset sequence.

## Interface
Parameters:
- SEQ_LEN, 7: cycles per sequence, c0..c6; fixed for 6502 compatibility.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  high = advance; low = freeze sequence state.
- nmi_n  in  1  NMI pin, active low, falling-edge sensitive.
- irq_n  in  1  IRQ pin, active low, level sensitive.
- i_flag  in  1  processor status I bit.
- sync  in  1  decoder flags the opcode-fetch cycle (instruction boundary).
- brk_op  in  1  decoder flags that IR holds 0x00 in the cycle after sync.
- force_brk  out  1  substitute 0x00 for the fetched opcode this cycle.
- int_active  out  1  sequence in progress.
- seq_cycle  out  3  current sequence cycle 0..6; 0 when idle.
- pc_inc_inhibit  out  1  suppress PC increment (hardware interrupts and reset only).
- suppress_write  out  1  convert push writes to reads (reset sequence only).
- b_flag  out  1  B bit value for the P push: 1 = BRK, 0 = otherwise.
- set_i  out  1  one-cycle pulse that sets P.I.
- vec_lo  out  8  vector address low byte, valid in c5/c6; high byte is always 0xFF.

## Operation
- States: IDLE, SEQ. SEQ holds src ∈ {RESET, NMI, IRQ, BRK} and cycle counter cnt.
- Pending sources:
  - nmi_pend is set when nmi_prev=1 and nmi_n=0. nmi_prev is a register of nmi_n.
  - nmi_pend is cleared in SEQ at c5 when src=NMI.
  - Edge capture continues while rdy=0.
  - irq_pend = ~irq_n & ~i_flag, evaluated combinationally, not latched.
- Entry from IDLE, only with rdy=1:
  - If sync=1 and (nmi_pend | irq_pend): force_brk=1 combinationally this cycle. Then go to SEQ with cnt=1, src=NMI if nmi_pend else IRQ.
  - Else if brk_op=1: go to SEQ with cnt=2, src=BRK. The BRK c0/c1 are the normal fetch plus operand-skip cycles.
- Priority: RESET > NMI > IRQ > BRK.
- Cycle roles:
  - c1: dummy read; pc_inc_inhibit=1 unless src=BRK.
  - c2: push PCH. c3: push PCL. c4: push P.
  - c5: fetch vector low byte; set_i=1.
  - c6: fetch vector high byte. Then IDLE.
- NMI hijack: in c1..c4 with src ∈ {IRQ, BRK} and nmi_pend=1, src becomes NMI at the next edge. b_flag keeps the value for the original src.
- Vectors:
  - vec_lo = FA for NMI, FC for RESET, FE for IRQ/BRK in c5.
  - vec_lo = that value | 0x01 in c6.
  - vec_lo = 0x00 otherwise.
- suppress_write=1 in c2..c4 only when src=RESET.
- rdy=0: cnt, src and state hold. Outputs hold their current values. set_i does not repeat.

## Timing
- While rst=1, all outputs and state take these values immediately (asynchronous):
  - state=SEQ, src=RESET, cnt=0.
  - int_active=1, seq_cycle=0, pc_inc_inhibit=1.
  - suppress_write=0, force_brk=0, set_i=0, b_flag=0, vec_lo=0x00.
  - nmi_pend=0, nmi_prev=1.
- After rst falls, cnt advances c0→c6 on successive rdy=1 edges. The first sync is expected one cycle after c6.
- Outputs are combinational from state, cnt, src and inputs; there are no extra pipeline stages.
- Latency from a qualifying sync to vec_lo=FE/FA is 5 cycles; the sequence occupies 7 cycles including the sync cycle.
- nmi_n falling 1 cycle before sync is taken at that sync. nmi_pend is visible the cycle after the edge.
- An NMI edge during its own sequence after c5 stays pending and is taken at the next sync.
- rst asserted mid-sequence aborts immediately to the reset values above.

## Test plan
- Reset release → int_active=1 for 7 cycles; suppress_write=1 in c2..c4; vec_lo=FC then FD; set_i pulse at c5; IDLE after.
- irq_n=0, i_flag=0, sync=1 → force_brk=1 that cycle; b_flag=0; vec_lo=FE/FF at c5/c6. Repeat with i_flag=1 → no entry.
- brk_op=1 → cnt starts at 2; pc_inc_inhibit=0; b_flag=1; vec_lo=FE/FF.
- IRQ sequence with nmi_n falling during c2 → vec_lo=FA/FB; b_flag=0; nmi_pend cleared at c5.
- rdy=0 for 3 cycles at c3 → seq_cycle stays 3; set_i pulses exactly once; an NMI edge during the stall is still captured.
- rst asserted at c4 of an NMI sequence → outputs go to reset values without waiting for a clock edge; nmi_pend=0.

Source files
------------

// File: rtl/int_sequencer.sv
// int_sequencer
//   Interrupt/reset sequencer for the 6502 core. Arbitrates RESET, NMI, IRQ
//   and BRK, then steps through the shared 7-cycle vector sequence:
//   c0/c1 opcode fetch (forced to 0x00 for hardware interrupts) and dummy
//   read, c2..c4 stack pushes (PCH, PCL, P), and c5/c6 vector fetch from
//   0xFFxx.
//
// Ports
//   clk            core clock, rising-edge
//   rst            asynchronous active-high reset; starts the RESET sequence
//   rdy            1 = advance, 0 = freeze sequence state
//   nmi_n          NMI pin, active low, falling-edge sensitive
//   irq_n          IRQ pin, active low, level sensitive
//   i_flag         processor status I bit (masks IRQ)
//   sync           opcode-fetch cycle from the decoder
//   brk_op         IR holds 0x00 in the cycle after sync
//   force_brk      substitute 0x00 for the fetched opcode this cycle
//   int_active     sequence in progress
//   seq_cycle      current sequence cycle 0..6 (0 when idle)
//   pc_inc_inhibit suppress PC increment (hardware interrupt / reset)
//   suppress_write turn push writes into reads (reset sequence)
//   b_flag         B bit for the P push (1 only for a BRK-started sequence)
//   set_i          single-cycle pulse that sets P.I
//   vec_lo         vector low byte in c5/c6, 0x00 otherwise
module int_sequencer #(
  parameter int SEQ_LEN = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       i_flag,
  input  logic       sync,
  input  logic       brk_op,
  output logic       force_brk,
  output logic       int_active,
  output logic [2:0] seq_cycle,
  output logic       pc_inc_inhibit,
  output logic       suppress_write,
  output logic       b_flag,
  output logic       set_i,
  output logic [7:0] vec_lo
);

  typedef enum logic {IDLE, SEQ} state_t;
  typedef enum logic [1:0] {SRC_RESET, SRC_NMI, SRC_IRQ, SRC_BRK} src_t;

  localparam logic [2:0] C_LAST = 3'(SEQ_LEN - 1);
  localparam logic [2:0] C_VLO  = 3'd5;

  state_t     state;
  src_t       src;
  logic [2:0] cnt;
  logic       nmi_pend;
  logic       nmi_prev;
  logic       brk_orig;   // sequence was started by BRK; survives NMI hijack
  logic       i_done;     // set_i already issued for this c5 (stall guard)

  logic irq_pend;
  logic nmi_edge;
  logic take_int;
  logic in_seq;

  function automatic logic [7:0] vec_base(input src_t s);
    case (s)
      SRC_NMI:   vec_base = 8'hFA;
      SRC_RESET: vec_base = 8'hFC;
      default:   vec_base = 8'hFE;
    endcase
  endfunction

  assign irq_pend = ~irq_n & ~i_flag;
  assign nmi_edge = nmi_prev & ~nmi_n;
  assign in_seq   = (state == SEQ);
  assign take_int = (state == IDLE) & rdy & sync & (nmi_pend | irq_pend);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SEQ;
      src      <= SRC_RESET;
      cnt      <= 3'd0;
      nmi_pend <= 1'b0;
      nmi_prev <= 1'b1;
      brk_orig <= 1'b0;
      i_done   <= 1'b0;
    end else begin
      // Edge detection runs regardless of rdy so no NMI is lost in a stall.
      nmi_prev <= nmi_n;
      i_done   <= in_seq && (cnt == C_VLO);

      // A fresh edge wins over the clear so an NMI arriving at c5 of its own
      // sequence remains pending for the next instruction boundary.
      if (nmi_edge)
        nmi_pend <= 1'b1;
      else if (rdy && in_seq && (cnt == C_VLO) && (src == SRC_NMI))
        nmi_pend <= 1'b0;

      if (rdy) begin
        unique case (state)
          IDLE: begin
            if (take_int) begin
              state    <= SEQ;
              cnt      <= 3'd1;
              src      <= nmi_pend ? SRC_NMI : SRC_IRQ;
              brk_orig <= 1'b0;
            end else if (brk_op) begin
              // BRK c0/c1 were the normal fetch and operand-skip cycles.
              state    <= SEQ;
              cnt      <= 3'd2;
              src      <= SRC_BRK;
              brk_orig <= 1'b1;
            end
          end
          SEQ: begin
            if (cnt == C_LAST) begin
              state    <= IDLE;
              cnt      <= 3'd0;
              brk_orig <= 1'b0;
            end else begin
              cnt <= cnt + 3'd1;
              // NMI hijack: before the vector fetch an NMI redirects an
              // IRQ/BRK sequence to the NMI vector.
              if ((cnt >= 3'd1) && (cnt <= 3'd4) && nmi_pend &&
                  ((src == SRC_IRQ) || (src == SRC_BRK)))
                src <= SRC_NMI;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    force_brk      = take_int;
    int_active     = in_seq;
    seq_cycle      = in_seq ? cnt : 3'd0;
    pc_inc_inhibit = in_seq && (src != SRC_BRK) && (cnt <= 3'd1);
    suppress_write = in_seq && (src == SRC_RESET) && (cnt >= 3'd2) && (cnt <= 3'd4);
    b_flag         = in_seq && brk_orig;
    set_i          = in_seq && (cnt == C_VLO) && !i_done;
    vec_lo         = 8'h00;
    if (in_seq && (cnt == C_VLO))
      vec_lo = vec_base(src);
    else if (in_seq && (cnt == C_LAST))
      vec_lo = vec_base(src) | 8'h01;
  end

endmodule

// File: tb/tb_int_sequencer.sv
module tb_int_sequencer;

  logic       clk = 1'b0;
  logic       rst, rdy, nmi_n, irq_n, i_flag, sync, brk_op;
  logic       force_brk, int_active, pc_inc_inhibit, suppress_write, b_flag, set_i;
  logic [2:0] seq_cycle;
  logic [7:0] vec_lo;

  int total = 0;
  int bad   = 0;

  int_sequencer #(.SEQ_LEN(7)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .nmi_n(nmi_n), .irq_n(irq_n),
    .i_flag(i_flag), .sync(sync), .brk_op(brk_op),
    .force_brk(force_brk), .int_active(int_active), .seq_cycle(seq_cycle),
    .pc_inc_inhibit(pc_inc_inhibit), .suppress_write(suppress_write),
    .b_flag(b_flag), .set_i(set_i), .vec_lo(vec_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  in;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[$];

  // inputs: {rst, rdy, nmi_n, irq_n, i_flag, sync, brk_op}
  function automatic logic [6:0] fi(input bit r, input bit y, input bit n,
                                    input bit q, input bit i, input bit s,
                                    input bit b);
    return {r, y, n, q, i, s, b};
  endfunction

  // outputs: {force_brk, int_active, seq_cycle, pc_inc_inhibit,
  //           suppress_write, b_flag, set_i, vec_lo}
  function automatic logic [16:0] fo(input bit fb, input bit ia, input int sc,
                                     input bit pi, input bit sw, input bit bf,
                                     input bit si, input logic [7:0] vl);
    return {fb, ia, 3'(sc), pi, sw, bf, si, vl};
  endfunction

  task automatic drive(input logic [6:0] in);
    {rst, rdy, nmi_n, irq_n, i_flag, sync, brk_op} = in;
  endtask

  task automatic check(input logic [16:0] exp, input string nm);
    logic [16:0] act;
    act = {force_brk, int_active, seq_cycle, pc_inc_inhibit, suppress_write,
           b_flag, set_i, vec_lo};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic step(input logic [6:0] in, input logic [16:0] exp, input string nm);
    drive(in);
    @(negedge clk);
    check(exp, nm);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [6:0] in, input logic [16:0] exp);
    tbl.push_back('{in: in, exp: exp});
  endtask

  logic [6:0]  idl;
  logic [16:0] z;

  initial begin
    idl = fi(0,1,1,1,1,0,0);
    z   = fo(0,0,0,0,0,0,0,8'h00);

    // Reset release: 7-cycle RESET sequence.
    add(idl, fo(0,1,0,1,0,0,0,8'h00));
    add(idl, fo(0,1,1,1,0,0,0,8'h00));
    add(idl, fo(0,1,2,0,1,0,0,8'h00));
    add(idl, fo(0,1,3,0,1,0,0,8'h00));
    add(idl, fo(0,1,4,0,1,0,0,8'h00));
    add(idl, fo(0,1,5,0,0,0,1,8'hFC));
    add(idl, fo(0,1,6,0,0,0,0,8'hFD));
    add(idl, z);
    // IRQ taken at sync.
    add(fi(0,1,1,0,0,1,0), fo(1,0,0,0,0,0,0,8'h00));
    add(fi(0,1,1,0,0,0,0), fo(0,1,1,1,0,0,0,8'h00));
    add(fi(0,1,1,0,0,0,0), fo(0,1,2,0,0,0,0,8'h00));
    add(fi(0,1,1,0,0,0,0), fo(0,1,3,0,0,0,0,8'h00));
    add(fi(0,1,1,0,0,0,0), fo(0,1,4,0,0,0,0,8'h00));
    add(fi(0,1,1,0,0,0,0), fo(0,1,5,0,0,0,1,8'hFE));
    add(fi(0,1,1,0,0,0,0), fo(0,1,6,0,0,0,0,8'hFF));
    add(fi(0,1,1,0,0,0,0), z);
    // IRQ masked by I, and no entry while rdy=0.
    add(fi(0,1,1,0,1,1,0), z);
    add(fi(0,1,1,0,1,0,0), z);
    add(fi(0,0,1,0,0,1,0), z);
    // BRK: starts at c2, B=1, no PC inhibit.
    add(fi(0,1,1,1,1,1,0), z);
    add(fi(0,1,1,1,1,0,1), z);
    add(idl, fo(0,1,2,0,0,1,0,8'h00));
    add(idl, fo(0,1,3,0,0,1,0,8'h00));
    add(idl, fo(0,1,4,0,0,1,0,8'h00));
    add(idl, fo(0,1,5,0,0,1,1,8'hFE));
    add(idl, fo(0,1,6,0,0,1,0,8'hFF));
    add(idl, z);
    // NMI edge one cycle before sync.
    add(fi(0,1,0,1,1,0,0), z);
    add(fi(0,1,0,1,1,1,0), fo(1,0,0,0,0,0,0,8'h00));
    add(fi(0,1,0,1,1,0,0), fo(0,1,1,1,0,0,0,8'h00));
    add(fi(0,1,0,1,1,0,0), fo(0,1,2,0,0,0,0,8'h00));
    add(fi(0,1,0,1,1,0,0), fo(0,1,3,0,0,0,0,8'h00));
    add(fi(0,1,0,1,1,0,0), fo(0,1,4,0,0,0,0,8'h00));
    add(fi(0,1,0,1,1,0,0), fo(0,1,5,0,0,0,1,8'hFA));
    add(fi(0,1,0,1,1,0,0), fo(0,1,6,0,0,0,0,8'hFB));
    add(fi(0,1,0,1,1,1,0), z);   // pending cleared, pin still low: no retake
    add(idl, z);

    // Asynchronous reset state.
    drive(fi(1,0,1,1,1,0,0));
    @(negedge clk);
    check(fo(0,1,0,1,0,0,0,8'h00), "reset");
    @(posedge clk);
    #1;

    for (int k = 0; k < tbl.size(); k++)
      step(tbl[k].in, tbl[k].exp, $sformatf("tbl[%0d]", k));

    // IRQ hijacked by an NMI edge in c2.
    step(fi(0,1,1,0,0,1,0), fo(1,0,0,0,0,0,0,8'h00), "hj sync");
    step(fi(0,1,1,0,0,0,0), fo(0,1,1,1,0,0,0,8'h00), "hj c1");
    step(fi(0,1,0,0,0,0,0), fo(0,1,2,0,0,0,0,8'h00), "hj c2");
    step(fi(0,1,0,0,0,0,0), fo(0,1,3,0,0,0,0,8'h00), "hj c3");
    step(fi(0,1,0,0,0,0,0), fo(0,1,4,0,0,0,0,8'h00), "hj c4");
    step(fi(0,1,0,0,0,0,0), fo(0,1,5,0,0,0,1,8'hFA), "hj c5");
    step(fi(0,1,0,0,0,0,0), fo(0,1,6,0,0,0,0,8'hFB), "hj c6");
    step(fi(0,1,0,1,1,1,0), z, "hj cleared");
    step(idl, z, "hj idle");

    // BRK with rdy stalls at c3 (NMI edge during stall) and at c5.
    step(fi(0,1,1,1,1,1,0), z, "st sync");
    step(fi(0,1,1,1,1,0,1), z, "st brk");
    step(idl,                fo(0,1,2,0,0,1,0,8'h00), "st c2");
    step(fi(0,0,0,1,1,0,0), fo(0,1,3,0,0,1,0,8'h00), "st c3a");
    step(fi(0,0,0,1,1,0,0), fo(0,1,3,0,0,1,0,8'h00), "st c3b");
    step(fi(0,0,0,1,1,0,0), fo(0,1,3,0,0,1,0,8'h00), "st c3c");
    step(fi(0,1,0,1,1,0,0), fo(0,1,3,0,0,1,0,8'h00), "st c3d");
    step(fi(0,1,0,1,1,0,0), fo(0,1,4,0,0,1,0,8'h00), "st c4");
    step(fi(0,0,0,1,1,0,0), fo(0,1,5,0,0,1,1,8'hFA), "st c5a");
    step(fi(0,0,0,1,1,0,0), fo(0,1,5,0,0,1,0,8'hFA), "st c5b");
    step(fi(0,1,0,1,1,0,0), fo(0,1,5,0,0,1,0,8'hFA), "st c5c");
    step(fi(0,1,0,1,1,0,0), fo(0,1,6,0,0,1,0,8'hFB), "st c6");
    step(fi(0,1,0,1,1,1,0), z, "st cleared");
    step(idl, z, "st idle");

    // rst asserted at c4 of an NMI sequence.
    step(fi(0,1,0,1,1,0,0), z, "ar edge");
    step(fi(0,1,0,1,1,1,0), fo(1,0,0,0,0,0,0,8'h00), "ar sync");
    step(idl, fo(0,1,1,1,0,0,0,8'h00), "ar c1");
    step(idl, fo(0,1,2,0,0,0,0,8'h00), "ar c2");
    step(idl, fo(0,1,3,0,0,0,0,8'h00), "ar c3");
    drive(idl);
    @(negedge clk);
    check(fo(0,1,4,0,0,0,0,8'h00), "ar c4");
    #1 rst = 1'b1;
    #1 check(fo(0,1,0,1,0,0,0,8'h00), "ar async");
    @(posedge clk);
    #1;
    step(fi(1,1,1,1,1,0,0), fo(0,1,0,1,0,0,0,8'h00), "ar held");
    for (int c = 0; c < 7; c++)
      step(idl, fo(0,1,c,(c <= 1),(c >= 2 && c <= 4),0,(c == 5),
                   (c == 5) ? 8'hFC : ((c == 6) ? 8'hFD : 8'h00)),
           $sformatf("ar rs c%0d", c));
    step(fi(0,1,1,1,1,1,0), z, "ar pend clr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
